div_issue_ctrl: RTL

Execute-stage sequencer for the RV32M divide instructions (DIV, DIVU, REM, REMU). It sits between the ID/EX pipeline register and the team's iterative divider. It registers operands, issues start to the divider and holds its inputs stable until done, and stalls the pipeline. It resolves the architectural special cases (divide-by-zero, signed overflow) without using the divider, and answers a DIV/REM pair on identical operands from a one-entry result cache.

---
 rtl/div_issue_pkg.sv | 31 +++
 rtl/div_issue_ctrl_if.sv | 39 +++
 rtl/div_result_cache.sv | 53 +++++
 rtl/div_issue_ctrl.sv | 138 +++++++++++++
 4 files changed

// File: rtl/div_issue_pkg.sv
// Shared encodings for the RV32M divide sequencer: funct3 op codes, FSM states
// and the architectural special-case constants.
package div_issue_pkg;

  localparam int DIV_WIDTH = 32;

  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;

  localparam logic [DIV_WIDTH-1:0] INT_MIN  = {1'b1, {(DIV_WIDTH-1){1'b0}}};
  localparam logic [DIV_WIDTH-1:0] ALL_ONES = {DIV_WIDTH{1'b1}};

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_DONE,
    ST_DRAIN
  } div_state_e;

  function automatic logic op_is_rem(input logic [1:0] op);
    return (op == OP_REM) || (op == OP_REMU);
  endfunction

  function automatic logic op_is_unsigned(input logic [1:0] op);
    return (op == OP_DIVU) || (op == OP_REMU);
  endfunction

endpackage

// File: rtl/div_issue_ctrl_if.sv
// Bundle of the EX-stage request/response and iterative-divider handshake.
// The slave view belongs to the sequencer; the master view to its surroundings.
interface div_issue_ctrl_if
  import div_issue_pkg::*;
#(
  parameter int DATA_WIDTH = DIV_WIDTH
);

  logic                  i_valid;
  logic [1:0]            i_op;
  logic [DATA_WIDTH-1:0] i_rs1;
  logic [DATA_WIDTH-1:0] i_rs2;
  logic                  i_flush;
  logic                  o_stall;
  logic                  o_valid;
  logic [DATA_WIDTH-1:0] o_result;
  logic                  o_div_start;
  logic                  o_div_unsigned;
  logic [DATA_WIDTH-1:0] o_div_a;
  logic [DATA_WIDTH-1:0] o_div_b;
  logic [DATA_WIDTH-1:0] i_div_quotient;
  logic [DATA_WIDTH-1:0] i_div_remainder;
  logic                  i_div_done;

  modport slave (
    input  i_valid, i_op, i_rs1, i_rs2, i_flush,
    input  i_div_quotient, i_div_remainder, i_div_done,
    output o_stall, o_valid, o_result,
    output o_div_start, o_div_unsigned, o_div_a, o_div_b
  );

  modport master (
    output i_valid, i_op, i_rs1, i_rs2, i_flush,
    output i_div_quotient, i_div_remainder, i_div_done,
    input  o_stall, o_valid, o_result,
    input  o_div_start, o_div_unsigned, o_div_a, o_div_b
  );

endinterface

// File: rtl/div_result_cache.sv
// One-entry memo of the last divider result, tagged by operands and signedness,
// so a DIV/REM pair on the same operands only pays the divider latency once.
module div_result_cache
  import div_issue_pkg::*;
#(
  parameter int DATA_WIDTH = DIV_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] rs1_i,
  input  logic [DATA_WIDTH-1:0] rs2_i,
  input  logic                  unsigned_i,
  output logic                  hit_o,
  output logic [DATA_WIDTH-1:0] quot_o,
  output logic [DATA_WIDTH-1:0] rem_o,
  input  logic                  we_i,
  input  logic [DATA_WIDTH-1:0] wr_rs1_i,
  input  logic [DATA_WIDTH-1:0] wr_rs2_i,
  input  logic                  wr_unsigned_i,
  input  logic [DATA_WIDTH-1:0] wr_quot_i,
  input  logic [DATA_WIDTH-1:0] wr_rem_i
);

  logic                  valid_q;
  logic                  uns_q;
  logic [DATA_WIDTH-1:0] rs1_q;
  logic [DATA_WIDTH-1:0] rs2_q;
  logic [DATA_WIDTH-1:0] quot_q;
  logic [DATA_WIDTH-1:0] rem_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      uns_q   <= 1'b0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
    end else if (we_i) begin
      valid_q <= 1'b1;
      uns_q   <= wr_unsigned_i;
      rs1_q   <= wr_rs1_i;
      rs2_q   <= wr_rs2_i;
      quot_q  <= wr_quot_i;
      rem_q   <= wr_rem_i;
    end
  end

  assign hit_o  = valid_q && (rs1_q == rs1_i) && (rs2_q == rs2_i) && (uns_q == unsigned_i);
  assign quot_o = quot_q;
  assign rem_o  = rem_q;

endmodule

// File: rtl/div_issue_ctrl.sv
// EX-stage sequencer for DIV/DIVU/REM/REMU: resolves special cases and cache hits
// locally, otherwise drives the iterative divider and stalls the pipeline.
module div_issue_ctrl
  import div_issue_pkg::*;
#(
  parameter int DATA_WIDTH = DIV_WIDTH
) (
  input logic             clk,
  input logic             rst,
  div_issue_ctrl_if.slave bus_io
);

  div_state_e            state_q, state_d;
  logic [1:0]            op_q, op_d;
  logic [DATA_WIDTH-1:0] rs1_q, rs1_d;
  logic [DATA_WIDTH-1:0] rs2_q, rs2_d;
  logic                  uns_q, uns_d;
  logic [DATA_WIDTH-1:0] result_q, result_d;

  logic                  req_unsigned;
  logic                  div_zero;
  logic                  sgn_ovf;
  logic                  cache_hit;
  logic [DATA_WIDTH-1:0] cache_quot;
  logic [DATA_WIDTH-1:0] cache_rem;
  logic                  cache_we;
  logic                  start;
  logic                  valid;

  assign req_unsigned = op_is_unsigned(bus_io.i_op);
  assign div_zero     = (bus_io.i_rs2 == '0);
  assign sgn_ovf      = !req_unsigned && (bus_io.i_rs1 == INT_MIN) && (bus_io.i_rs2 == ALL_ONES);

  div_result_cache #(.DATA_WIDTH(DATA_WIDTH)) u_cache (
    .clk           (clk),
    .rst           (rst),
    .rs1_i         (bus_io.i_rs1),
    .rs2_i         (bus_io.i_rs2),
    .unsigned_i    (req_unsigned),
    .hit_o         (cache_hit),
    .quot_o        (cache_quot),
    .rem_o         (cache_rem),
    .we_i          (cache_we),
    .wr_rs1_i      (rs1_q),
    .wr_rs2_i      (rs2_q),
    .wr_unsigned_i (uns_q),
    .wr_quot_i     (bus_io.i_div_quotient),
    .wr_rem_i      (bus_io.i_div_remainder)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_DIV;
      rs1_q    <= '0;
      rs2_q    <= '0;
      uns_q    <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      rs1_q    <= rs1_d;
      rs2_q    <= rs2_d;
      uns_q    <= uns_d;
      result_q <= result_d;
    end
  end

  // Operand registers double as the divider inputs, so they only change in IDLE.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    rs1_d    = rs1_q;
    rs2_d    = rs2_q;
    uns_d    = uns_q;
    result_d = result_q;
    cache_we = 1'b0;
    start    = 1'b0;
    valid    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus_io.i_valid && !bus_io.i_flush) begin
          op_d    = bus_io.i_op;
          rs1_d   = bus_io.i_rs1;
          rs2_d   = bus_io.i_rs2;
          uns_d   = req_unsigned;
          state_d = ST_DONE;
          if (div_zero) begin
            result_d = op_is_rem(bus_io.i_op) ? bus_io.i_rs1 : ALL_ONES;
          end else if (sgn_ovf) begin
            result_d = op_is_rem(bus_io.i_op) ? '0 : INT_MIN;
          end else if (cache_hit) begin
            result_d = op_is_rem(bus_io.i_op) ? cache_rem : cache_quot;
          end else begin
            state_d = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        start   = 1'b1;
        state_d = bus_io.i_flush ? ST_DRAIN : ST_WAIT;
      end
      ST_WAIT: begin
        if (bus_io.i_div_done) begin
          cache_we = 1'b1;
          if (bus_io.i_flush) begin
            state_d = ST_IDLE;
          end else begin
            result_d = op_is_rem(op_q) ? bus_io.i_div_remainder : bus_io.i_div_quotient;
            state_d  = ST_DONE;
          end
        end else if (bus_io.i_flush) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DONE: begin
        valid   = !bus_io.i_flush;
        state_d = ST_IDLE;
      end
      ST_DRAIN: begin
        if (bus_io.i_div_done) begin
          cache_we = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus_io.o_stall        = bus_io.i_valid && (state_q != ST_DONE) && !bus_io.i_flush;
  assign bus_io.o_valid        = valid;
  assign bus_io.o_result       = result_q;
  assign bus_io.o_div_start    = start;
  assign bus_io.o_div_unsigned = uns_q;
  assign bus_io.o_div_a        = rs1_q;
  assign bus_io.o_div_b        = rs2_q;

endmodule
